// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, parity mode codes, frame width
// and small helpers used by both the receiver and transmitter.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } uart_state_t;

    localparam int PARITY_NONE = 0;
    localparam int PARITY_ODD  = 1;
    localparam int PARITY_EVEN = 2;

    localparam int FRAME_BITS  = 8;

    // Prescaler divide ratio: floor(clk / (baud * oversample)), never below 1.
    function automatic int calc_div(input int clk_freq, input int baud, input int os);
        int d;
        d = clk_freq / (baud * os);
        return (d < 1) ? 1 : d;
    endfunction

    // Two-out-of-three vote used for noise-tolerant bit recovery.
    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    // Parity bit the transmitter should have sent for this data byte.
    function automatic logic parity_bit(input logic [FRAME_BITS-1:0] d, input int mode);
        return (mode == PARITY_ODD) ? ~(^d) : (^d);
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Baud-rate prescaler: counts 0..DIV-1 and emits a one-cycle tick at DIV-1.
// A synchronous clear restarts the count so ticks can be phase-aligned to an
// external event (the start edge on RX, the start of a frame on TX).
module uart_baud_tick #(
    parameter int DIV = 13
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    output logic tick
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt_reg;

    // Free-running modulo-DIV counter with synchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_reg <= '0;
        end else if (clr || (cnt_reg == LAST)) begin
            cnt_reg <= '0;
        end else begin
            cnt_reg <= cnt_reg + 1'b1;
        end
    end

    // A clear in the same cycle suppresses the tick so the new phase starts clean.
    assign tick = (cnt_reg == LAST) && !clr;

endmodule

// File: rtl/uart_rx_os.sv
// Oversampling UART receiver (8N1 / 8O1 / 8E1, LSB first).
// Each bit is sampled three times around its midpoint and decided by majority.
// Good frames update dout_rx with a one-cycle done_rx; a low stop bit gives a
// frame_err pulse instead, and a parity mismatch rides along with done_rx.
module uart_rx_os
    import uart_pkg::*;
#(
    parameter int CLK_FREQ   = 1_000_000,
    parameter int BAUD       = 9600,
    parameter int OVERSAMPLE = 8,
    parameter int PARITY     = 0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    output logic [7:0] dout_rx,
    output logic       done_rx,
    output logic       frame_err,
    output logic       parity_err,
    output logic       busy
);

    localparam int DIV = calc_div(CLK_FREQ, BAUD, OVERSAMPLE);
    localparam int SW  = $clog2(OVERSAMPLE);

    localparam logic [SW-1:0] S_LAST  = SW'(OVERSAMPLE - 1);
    localparam logic [SW-1:0] S_THIRD = SW'(OVERSAMPLE / 2 + 1);

    // Synchroniser and edge-detect history; all idle high out of reset.
    logic rx_meta_reg;
    logic rx_s_reg;
    logic rx_prev_reg;

    uart_state_t           state_reg;
    logic [SW-1:0]         s_cnt_reg;
    logic [2:0]            bit_idx_reg;
    logic [FRAME_BITS-1:0] shift_reg;
    logic                  par_bad_reg;
    logic [2:0]            samp_reg;

    logic       fall_edge;
    logic       start_clr;
    logic       tick;
    logic [2:0] samp_hit;
    logic       bit_end;
    logic       bit_maj;
    logic       stop_maj;

    // Two-flop synchroniser plus one flop of history for falling-edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta_reg <= 1'b1;
            rx_s_reg    <= 1'b1;
            rx_prev_reg <= 1'b1;
        end else begin
            rx_meta_reg <= rx;
            rx_s_reg    <= rx_meta_reg;
            rx_prev_reg <= rx_s_reg;
        end
    end

    // Only a genuine 1->0 transition starts a frame; a held-low line does not.
    assign fall_edge = rx_prev_reg & ~rx_s_reg;
    assign start_clr = (state_reg == ST_IDLE) && fall_edge;

    uart_baud_tick #(
        .DIV(DIV)
    ) u_baud_tick (
        .clk  (clk),
        .rst_n(rst_n),
        .clr  (start_clr),
        .tick (tick)
    );

    // The three sample points sit at OS/2-1, OS/2 and OS/2+1 within each bit.
    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_samp_hit
            assign samp_hit[gi] = (s_cnt_reg == SW'(OVERSAMPLE / 2 - 1 + gi));
        end
    endgenerate

    // Capture the line at each of the three mid-bit sample points.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            samp_reg <= 3'b111;
        end else if (tick && (state_reg != ST_IDLE)) begin
            for (int i = 0; i < 3; i++) begin
                if (samp_hit[i]) begin
                    samp_reg[i] <= rx_s_reg;
                end
            end
        end
    end

    assign bit_end  = tick && (s_cnt_reg == S_LAST);
    assign bit_maj  = majority3(samp_reg[0], samp_reg[1], samp_reg[2]);
    // The stop decision is made on the third sample itself, so that sample is
    // taken straight from the synchroniser rather than from samp_reg.
    assign stop_maj = majority3(samp_reg[0], samp_reg[1], rx_s_reg);

    // Frame FSM with sample/bit counters and registered result strobes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= ST_IDLE;
            s_cnt_reg   <= '0;
            bit_idx_reg <= '0;
            shift_reg   <= '0;
            par_bad_reg <= 1'b0;
            dout_rx     <= '0;
            done_rx     <= 1'b0;
            frame_err   <= 1'b0;
            parity_err  <= 1'b0;
        end else begin
            done_rx    <= 1'b0;
            frame_err  <= 1'b0;
            parity_err <= 1'b0;

            if (state_reg == ST_IDLE) begin
                if (fall_edge) begin
                    state_reg   <= ST_START;
                    s_cnt_reg   <= '0;
                    par_bad_reg <= 1'b0;
                end
            end else if (tick) begin
                s_cnt_reg <= (s_cnt_reg == S_LAST) ? '0 : s_cnt_reg + 1'b1;

                case (state_reg)
                    ST_START: begin
                        if (bit_end) begin
                            // A start bit that votes high was a glitch.
                            state_reg   <= bit_maj ? ST_IDLE : ST_DATA;
                            bit_idx_reg <= '0;
                        end
                    end
                    ST_DATA: begin
                        if (bit_end) begin
                            shift_reg <= {bit_maj, shift_reg[FRAME_BITS-1:1]};
                            if (bit_idx_reg == 3'(FRAME_BITS - 1)) begin
                                state_reg <= (PARITY != PARITY_NONE) ? ST_PARITY : ST_STOP;
                            end else begin
                                bit_idx_reg <= bit_idx_reg + 1'b1;
                            end
                        end
                    end
                    ST_PARITY: begin
                        if (bit_end) begin
                            par_bad_reg <= (bit_maj != parity_bit(shift_reg, PARITY));
                            state_reg   <= ST_STOP;
                        end
                    end
                    ST_STOP: begin
                        // Decide early, at the third sample, so the next start
                        // edge can arrive right after a one-bit stop.
                        if (s_cnt_reg == S_THIRD) begin
                            if (stop_maj) begin
                                dout_rx    <= shift_reg;
                                done_rx    <= 1'b1;
                                parity_err <= (PARITY != PARITY_NONE) && par_bad_reg;
                            end else begin
                                frame_err <= 1'b1;
                            end
                            state_reg <= ST_IDLE;
                            s_cnt_reg <= '0;
                        end
                    end
                    default: begin
                        state_reg <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign busy = (state_reg != ST_IDLE);

endmodule

// File: tb/tb_uart_rx_os.sv
// Self-checking bench for uart_rx_os: a table of frames (exact and +/-3% bit
// timing, with and without parity) plus hand-written glitch, break and
// mid-frame reset sequences. Expected events go into a scoreboard queue when a
// frame is driven and are popped when the DUT strobes done_rx/frame_err.
module tb_uart_rx_os;

    localparam int BIT_CLK = 104;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic line  = 1'b1;
    logic sel   = 1'b0;   // 0: drive the no-parity DUT, 1: the even-parity DUT

    logic rx0, rx2;
    logic [7:0] dout0, dout2;
    logic done0, ferr0, perr0, busy0;
    logic done2, ferr2, perr2, busy2;

    assign rx0 = sel ? 1'b1 : line;
    assign rx2 = sel ? line : 1'b1;

    always #5 clk = ~clk;

    uart_rx_os #(
        .CLK_FREQ(1_000_000), .BAUD(9600), .OVERSAMPLE(8), .PARITY(0)
    ) dut0 (
        .clk(clk), .rst_n(rst_n), .rx(rx0), .dout_rx(dout0), .done_rx(done0),
        .frame_err(ferr0), .parity_err(perr0), .busy(busy0)
    );

    uart_rx_os #(
        .CLK_FREQ(1_000_000), .BAUD(9600), .OVERSAMPLE(8), .PARITY(2)
    ) dut2 (
        .clk(clk), .rst_n(rst_n), .rx(rx2), .dout_rx(dout2), .done_rx(done2),
        .frame_err(ferr2), .parity_err(perr2), .busy(busy2)
    );

    typedef struct {
        logic [7:0] dout;
        logic       done;
        logic       ferr;
        logic       perr;
    } exp_t;

    typedef struct {
        logic [7:0] data;
        logic       stop_b;
        int         bitlen;
        logic       psel;
        logic       par_b;
        int         idle_after;
        exp_t       exp;
    } vec_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   errors = 0;
    int   checks = 0;

    logic [7:0] m_dout;
    logic       m_done, m_ferr, m_perr;
    assign m_dout = sel ? dout2 : dout0;
    assign m_done = sel ? done2 : done0;
    assign m_ferr = sel ? ferr2 : ferr0;
    assign m_perr = sel ? perr2 : perr0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(posedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop_b, input int bitlen,
                              input logic has_par, input logic par_b, input int idle_after);
        line = 1'b0;
        wait_clks(bitlen);
        for (int b = 0; b < 8; b++) begin
            line = d[b];
            wait_clks(bitlen);
        end
        if (has_par) begin
            line = par_b;
            wait_clks(bitlen);
        end
        line = stop_b;
        wait_clks(bitlen);
        if (idle_after > 0) begin
            line = 1'b1;
            wait_clks(idle_after);
        end
    endtask

    task automatic push_exp(input logic [7:0] d, input logic dn, input logic fe, input logic pe);
        exp_t e;
        e.dout = d; e.done = dn; e.ferr = fe; e.perr = pe;
        exp_q.push_back(e);
    endtask

    task automatic drain(input string name);
        for (int k = 0; k < 3000 && exp_q.size() != 0; k++) @(posedge clk);
        chk(name, 32'(exp_q.size()), 0);
    endtask

    // Scoreboard monitor: every result strobe must match the oldest expectation.
    always @(negedge clk) begin
        if (rst_n && (m_done || m_ferr || m_perr)) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_event", {29'd0, m_done, m_ferr, m_perr}, 32'd0);
            end else begin
                mon_e = exp_q.pop_front();
                $display("rx event dut%0d: dout=%02h done=%0b ferr=%0b perr=%0b (want %02h %0b %0b %0b)",
                         sel ? 2 : 0, m_dout, m_done, m_ferr, m_perr,
                         mon_e.dout, mon_e.done, mon_e.ferr, mon_e.perr);
                chk("done_rx", 32'(m_done), 32'(mon_e.done));
                chk("frame_err", 32'(m_ferr), 32'(mon_e.ferr));
                chk("parity_err", 32'(m_perr), 32'(mon_e.perr));
                chk("dout_rx", 32'(m_dout), 32'(mon_e.dout));
            end
        end
    end

    vec_t vecs[15];

    function automatic vec_t mk(input logic [7:0] d, input logic sb, input int bl, input logic ps,
                                input logic pb, input int idle, input logic [7:0] ed,
                                input logic dn, input logic fe, input logic pe);
        vec_t v;
        v.data = d; v.stop_b = sb; v.bitlen = bl; v.psel = ps; v.par_b = pb;
        v.idle_after = idle;
        v.exp.dout = ed; v.exp.done = dn; v.exp.ferr = fe; v.exp.perr = pe;
        return v;
    endfunction

    initial begin
        // data  stop bitlen psel parb idle | dout done ferr perr
        vecs[0]  = mk(8'hA5, 1, 104, 0, 0, 104, 8'hA5, 1, 0, 0);
        vecs[1]  = mk(8'h00, 1, 104, 0, 0,   0, 8'h00, 1, 0, 0);
        vecs[2]  = mk(8'hFF, 1, 104, 0, 0,   0, 8'hFF, 1, 0, 0);
        vecs[3]  = mk(8'h3C, 1, 104, 0, 0, 104, 8'h3C, 1, 0, 0);
        vecs[4]  = mk(8'h5A, 0, 104, 0, 0, 208, 8'h3C, 0, 1, 0);
        vecs[5]  = mk(8'hA5, 1, 101, 0, 0, 104, 8'hA5, 1, 0, 0);
        vecs[6]  = mk(8'hC3, 1, 107, 0, 0, 104, 8'hC3, 1, 0, 0);
        vecs[7]  = mk(8'h5A, 0, 101, 0, 0, 208, 8'hC3, 0, 1, 0);
        vecs[8]  = mk(8'h5A, 0, 107, 0, 0, 208, 8'hC3, 0, 1, 0);
        vecs[9]  = mk(8'h07, 1, 104, 1, 0, 104, 8'h07, 1, 0, 1);
        vecs[10] = mk(8'h07, 1, 104, 1, 1, 104, 8'h07, 1, 0, 0);
        vecs[11] = mk(8'h07, 1, 101, 1, 0, 104, 8'h07, 1, 0, 1);
        vecs[12] = mk(8'hE1, 1, 107, 1, 0, 104, 8'hE1, 1, 0, 0);
        vecs[13] = mk(8'hE1, 0, 104, 1, 1, 208, 8'hE1, 0, 1, 0);
        vecs[14] = mk(8'h18, 1, 107, 1, 1, 104, 8'h18, 1, 0, 1);

        // Reset state.
        wait_clks(5);
        #1;
        chk("reset_dout0", 32'(dout0), 0);
        chk("reset_strobes0", {29'd0, done0, ferr0, perr0}, 0);
        chk("reset_busy0", 32'(busy0), 0);
        chk("reset_dout2", 32'(dout2), 0);
        rst_n = 1'b1;
        wait_clks(20);

        // Table-driven frames.
        for (int i = 0; i < 15; i++) begin
            sel = vecs[i].psel;
            push_exp(vecs[i].exp.dout, vecs[i].exp.done, vecs[i].exp.ferr, vecs[i].exp.perr);
            send_frame(vecs[i].data, vecs[i].stop_b, vecs[i].bitlen, vecs[i].psel,
                       vecs[i].par_b, vecs[i].idle_after);
        end
        drain("table_drain");

        // Start-bit glitch: 30 clk low must be rejected silently.
        sel  = 1'b0;
        line = 1'b0;
        wait_clks(30);
        line = 1'b1;
        #1;
        chk("glitch_busy_high", 32'(busy0), 1);
        wait_clks(BIT_CLK - 30 + 12);
        #1;
        chk("glitch_busy_low", 32'(busy0), 0);
        wait_clks(200);

        // Frame error then a long break: exactly one frame_err, dout_rx kept.
        push_exp(8'hC3, 0, 1, 0);
        send_frame(8'h5A, 1'b0, BIT_CLK, 1'b0, 1'b0, 0);
        wait_clks(3 * 10 * BIT_CLK);
        #1;
        chk("break_busy", 32'(busy0), 0);
        chk("break_dout", 32'(dout0), 32'h0000_00C3);
        line = 1'b1;
        wait_clks(300);
        chk("break_drain", 32'(exp_q.size()), 0);

        // Mid-frame reset during data bit 4 of 0x81.
        line = 1'b0;
        wait_clks(BIT_CLK);
        for (int b = 0; b < 4; b++) begin
            line = (b == 0) ? 1'b1 : 1'b0;
            wait_clks(BIT_CLK);
        end
        line = 1'b0;
        wait_clks(BIT_CLK / 2);
        chk("pre_reset_busy", 32'(busy0), 1);
        rst_n = 1'b0;
        #1;
        chk("abort_dout0", 32'(dout0), 0);
        chk("abort_busy0", 32'(busy0), 0);
        chk("abort_strobes0", {29'd0, done0, ferr0, perr0}, 0);
        chk("abort_dout2", 32'(dout2), 0);
        line = 1'b1;
        wait_clks(20);
        rst_n = 1'b1;
        wait_clks(50);
        #1;
        chk("post_reset_busy", 32'(busy0), 0);
        push_exp(8'h81, 1, 0, 0);
        send_frame(8'h81, 1'b1, BIT_CLK, 1'b0, 1'b0, 104);
        drain("final_drain");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
